// File: rtl/uart_tx.sv
// Byte-serialising UART transmitter: start(1), 8 data bits LSB first, stop(0); idle line is 0.
// Define UART_TX_PARITY_EN to insert an even-parity bit between D7 and the stop bit.
module uart_tx (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic       bit_clk,
    input  logic       send,
    input  logic [7:0] in,
    output logic       done,
    output logic       out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_bit;
    logic [2:0] w_bit_next;
    logic [7:0] r_shift;
    logic       w_load;
    logic       r_out;
    logic       r_done;
    logic       w_out_next;
    logic       w_done_next;

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_bit   <= '0;
            r_shift <= '0;
            r_out   <= 1'b0;
            r_done  <= 1'b0;
        end else if (bit_clk) begin
            r_state <= w_state_next;
            r_bit   <= w_bit_next;
            r_out   <= w_out_next;
            r_done  <= w_done_next;
            if (w_load) begin
                r_shift <= in;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit;
        w_load       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (send) begin
                    w_state_next = S_START;
                    w_load       = 1'b1;
                end
            end
            S_START: begin
                w_state_next = S_DATA;
                w_bit_next   = '0;
            end
            S_DATA: begin
                if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end else begin
                    w_bit_next = r_bit + 3'd1;
                end
            end
            S_PARITY: begin
                w_state_next = S_STOP;
            end
            S_STOP: begin
                if (send) begin
                    w_state_next = S_START;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Line and strobe are decoded from the state being entered so both are registered.
    always_comb begin
        w_out_next  = 1'b0;
        w_done_next = 1'b0;
        unique case (w_state_next)
            S_IDLE:   w_out_next = 1'b0;
            S_START:  w_out_next = 1'b1;
            S_DATA:   w_out_next = r_shift[w_bit_next];
            S_PARITY: w_out_next = ^r_shift;
            S_STOP: begin
                w_out_next  = 1'b0;
                w_done_next = 1'b1;
            end
            default:  w_out_next = 1'b0;
        endcase
    end

    assign out  = r_out;
    assign done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: expected (out,done) per enabled edge is queued when a frame
// is requested and popped as the line is sampled; data bits are also reassembled into bytes.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic       ref_clk;
    logic       reset;
    logic       bit_clk;
    logic       send;
    logic [7:0] tb_in;
    logic       done_s;
    logic       out_s;

    logic [1:0] sb[$];
    logic [7:0] byte_q[$];
    int         checks;
    int         failures;
    logic       obs_out;
    logic       obs_done;
    logic [1:0] exp;
    logic [7:0] rx;
    logic [7:0] exp_byte;
    int         pos;

    uart_tx dut (
        .ref_clk (ref_clk),
        .reset   (reset),
        .bit_clk (bit_clk),
        .send    (send),
        .in      (tb_in),
        .done    (done_s),
        .out     (out_s)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    task automatic tick();
        @(posedge ref_clk);
        #1;
        obs_out  = out_s;
        obs_done = done_s;
    endtask

    task automatic push_frame(input logic [7:0] b);
        sb.push_back(2'b10);
        for (int i = 0; i < 8; i++) sb.push_back({b[i], 1'b0});
`ifdef UART_TX_PARITY_EN
        sb.push_back({^b, 1'b0});
`endif
        sb.push_back(2'b01);
    endtask

    task automatic test_reset();
        reset = 1'b1; send = 1'b0; bit_clk = 1'b1; tb_in = 8'h00;
        tick(); tick();
        checks++;
        if ({obs_out, obs_done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=00", {obs_out, obs_done});
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({obs_out, obs_done} !== 2'b00) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=00", c, {obs_out, obs_done});
            end
        end
    endtask

    task automatic test_single();
        tb_in = 8'hA9; send = 1'b1;
        push_frame(8'hA9);
        for (int c = 0; c < FRAME; c++) begin
            tick();
            if (c == 0) send = 1'b0;
            exp = sb.pop_front();
            checks++;
            if ({obs_out, obs_done} !== exp) begin
                failures++;
                $display("FAIL single cyc=%0d got=%b exp=%b", c, {obs_out, obs_done}, exp);
            end
        end
        tick();
        checks++;
        if ({obs_out, obs_done} !== 2'b00) begin
            failures++;
            $display("FAIL single_idle got=%b exp=00", {obs_out, obs_done});
        end
    endtask

    task automatic test_back_to_back();
        tb_in = 8'hCA; send = 1'b1;
        push_frame(8'hCA); byte_q.push_back(8'hCA);
        pos = 0; rx = '0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            if (c == FRAME) send = 1'b0;
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL b2b_empty cyc=%0d got=%b exp=none", c, {obs_out, obs_done});
            end else begin
                exp = sb.pop_front();
                checks++;
                if ({obs_out, obs_done} !== exp) begin
                    failures++;
                    $display("FAIL b2b cyc=%0d got=%b exp=%b", c, {obs_out, obs_done}, exp);
                end
            end
            if (pos >= 1 && pos <= 8) rx[pos-1] = obs_out;
            pos++;
            if (obs_done) begin
                exp_byte = (byte_q.size() != 0) ? byte_q.pop_front() : 8'hxx;
                checks++;
                if (rx !== exp_byte) begin
                    failures++;
                    $display("FAIL b2b_byte got=%h exp=%h", rx, exp_byte);
                end
                pos = 0;
            end
            if (c == FRAME - 1) begin
                tb_in = 8'hD2;
                push_frame(8'hD2); byte_q.push_back(8'hD2);
            end
        end
        tick();
        checks++;
        if ({obs_out, obs_done} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_idle got=%b exp=00", {obs_out, obs_done});
        end
    endtask

    task automatic test_handshake();
        logic [7:0] bytes [3];
        int idx;
        logic prev_done;
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3;
        idx = 0; prev_done = 1'b0; pos = 0; rx = '0;
        tb_in = bytes[0]; send = 1'b1;
        push_frame(bytes[0]); byte_q.push_back(bytes[0]);
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick();
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL hs_empty cyc=%0d got=%b exp=none", c, {obs_out, obs_done});
            end else begin
                exp = sb.pop_front();
                checks++;
                if ({obs_out, obs_done} !== exp) begin
                    failures++;
                    $display("FAIL hs cyc=%0d got=%b exp=%b", c, {obs_out, obs_done}, exp);
                end
            end
            if (pos >= 1 && pos <= 8) rx[pos-1] = obs_out;
            pos++;
            if (obs_done && !prev_done) begin
                exp_byte = (byte_q.size() != 0) ? byte_q.pop_front() : 8'hxx;
                checks++;
                if (rx !== exp_byte) begin
                    failures++;
                    $display("FAIL hs_byte idx=%0d got=%h exp=%h", idx, rx, exp_byte);
                end
                pos = 0;
                idx++;
                if (idx < 3) begin
                    tb_in = bytes[idx];
                    push_frame(bytes[idx]); byte_q.push_back(bytes[idx]);
                end else begin
                    send = 1'b0;
                end
            end
            prev_done = obs_done;
        end
        tick();
        checks++;
        if ({obs_out, obs_done} !== 2'b00) begin
            failures++;
            $display("FAIL hs_idle got=%b exp=00", {obs_out, obs_done});
        end
    endtask

    task automatic test_midframe_change();
        tb_in = 8'h3C; send = 1'b1;
        push_frame(8'h3C);
        for (int c = 0; c < FRAME; c++) begin
            tick();
            if (c == 0) begin send = 1'b0; tb_in = 8'hFF; end
            if (c == 4) tb_in = 8'h00;
            exp = sb.pop_front();
            checks++;
            if ({obs_out, obs_done} !== exp) begin
                failures++;
                $display("FAIL midchg cyc=%0d got=%b exp=%b", c, {obs_out, obs_done}, exp);
            end
        end
        tick();
        checks++;
        if ({obs_out, obs_done} !== 2'b00) begin
            failures++;
            $display("FAIL midchg_idle got=%b exp=00", {obs_out, obs_done});
        end
    endtask

    task automatic test_bitclk_hold();
        logic [1:0] held;
        int e;
        held = 2'b00; e = 0;
        tb_in = 8'h5B; send = 1'b1;
        push_frame(8'h5B);
        for (int c = 0; c < 2 * FRAME; c++) begin
            bit_clk = (c % 2 == 0);
            tick();
            if (bit_clk) begin
                e++;
                if (e == 1) send = 1'b0;
                exp = sb.pop_front();
            end else begin
                exp = held;
            end
            checks++;
            if ({obs_out, obs_done} !== exp) begin
                failures++;
                $display("FAIL bitclk cyc=%0d en=%0b got=%b exp=%b", c, bit_clk, {obs_out, obs_done}, exp);
            end
            held = {obs_out, obs_done};
        end
        bit_clk = 1'b1;
        tick();
        checks++;
        if ({obs_out, obs_done} !== 2'b00) begin
            failures++;
            $display("FAIL bitclk_idle got=%b exp=00", {obs_out, obs_done});
        end
    endtask

    task automatic test_reset_midframe();
        tb_in = 8'h5A; send = 1'b1;
        push_frame(8'h5A);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) send = 1'b0;
            exp = sb.pop_front();
            checks++;
            if ({obs_out, obs_done} !== exp) begin
                failures++;
                $display("FAIL rstmid_pre cyc=%0d got=%b exp=%b", c, {obs_out, obs_done}, exp);
            end
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({out_s, done_s} !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_async got=%b exp=00", {out_s, done_s});
        end
        sb.delete();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({obs_out, obs_done} !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_release got=%b exp=00", {obs_out, obs_done});
        end
        tb_in = 8'h69; send = 1'b1;
        push_frame(8'h69);
        for (int c = 0; c < FRAME; c++) begin
            tick();
            if (c == 0) send = 1'b0;
            exp = sb.pop_front();
            checks++;
            if ({obs_out, obs_done} !== exp) begin
                failures++;
                $display("FAIL rstmid_post cyc=%0d got=%b exp=%b", c, {obs_out, obs_done}, exp);
            end
        end
        tick();
        checks++;
        if ({obs_out, obs_done} !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_idle got=%b exp=00", {obs_out, obs_done});
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_handshake();
        test_midframe_change();
        test_bitclk_hold();
        test_reset_midframe();
        checks++;
        if (sb.size() !== 0 || byte_q.size() !== 0) begin
            failures++;
            $display("FAIL leftover sb=%0d bytes=%0d exp=0", sb.size(), byte_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
